run_control: RTL and testbench
==============================

RUN_CONTROL -- requirements
Module: run_control

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- ADDR_W, ADDR_WIDTH from arch_defs_pkg, program-counter width.
- NUM_BP, 4, number of hardware breakpoint slots (1..16).
- TIMEOUT_CYCLES, 0, watchdog limit in enabled cycles (0 = watchdog disabled).
- START_HALTED, 0, state on reset release (0 = RUN, 1 = HALTED).
REQ-002 Ports (name, direction, width, meaning), one per line; one clock; reset is synchronous and active-high:
- clk  in  1  system clock.
- reset  in  1  synchronous active-high reset.
- hlt_i  in  1  decoder HLT strobe, one cycle, during HLT execute.
- pc_i  in  ADDR_W  current program counter.
- instr_boundary_i  in  1  high in the first fetch cycle of each instruction.
- run_req_i  in  1  resume pulse.
- step_req_i  in  1  single-step pulse.
- bp_wr_en_i  in  1  breakpoint slot write strobe.
- bp_wr_idx_i  in  $clog2(NUM_BP) (min 1)  slot index.
- bp_wr_addr_i  in  ADDR_W  breakpoint address.
- bp_wr_valid_i  in  1  slot enable written with the address.
- cpu_en_o  out  1  CPU clock-enable; CPU state advances only when high.
- halt_o  out  1  high in HALTED state.
- halt_cause_o  out  3  halt_cause_t: NONE, HLT, BREAK, STEP, TIMEOUT, EXTERNAL.
- halted_pc_o  out  ADDR_W  pc_i captured on entry to HALTED.
- cycle_count_o  out  32  count of cpu_en_o-high cycles, saturating.

Function
REQ-003 FSM states: RUN, STEP, HALTED; state and all outputs except cpu_en_o are registered.
REQ-004 cpu_en_o = (state is RUN or STEP) AND NOT bp_hit AND NOT step_done AND NOT wd_expire (combinational).
REQ-005 bp_hit = instr_boundary_i AND any valid slot address equals pc_i AND NOT bp_skip.
REQ-006 hlt_i in RUN or STEP: the HLT instruction completes in that cycle; the next edge enters HALTED with cause HLT; cpu_en_o is low from the next cycle.
REQ-007 bp_hit: cpu_en_o is low in the same cycle, so the instruction at the breakpoint is not fetched; the next edge enters HALTED with cause BREAK and halted_pc_o = pc_i.
REQ-008 Priority when events coincide: HLT > BREAK > STEP > TIMEOUT.
REQ-009 HALTED + run_req_i: enter RUN next edge, set bp_skip, clear the watchdog, set cause NONE.
REQ-010 HALTED + step_req_i (without run_req_i): enter STEP next edge, set bp_skip.
REQ-011 run_req_i and step_req_i together: run wins.
REQ-012 Requests outside HALTED are ignored.
REQ-013 bp_skip clears at the first enabled cycle with instr_boundary_i low, so resume never re-hits the breakpoint it stopped on.
REQ-014 STEP: step_done = instr_boundary_i AND at least one enabled non-boundary cycle has occurred since entry; step_done forces cpu_en_o low; the next edge enters HALTED with cause STEP. Exactly one instruction executes per step.
REQ-015 Watchdog (TIMEOUT_CYCLES > 0): counts enabled cycles in RUN only; wd_expire = count == TIMEOUT_CYCLES; the next edge enters HALTED with cause TIMEOUT.
REQ-016 Breakpoint write: takes effect at the next edge; a match in the same cycle uses the old slot contents; a write with bp_wr_valid_i = 0 disables the slot.
REQ-017 cycle_count_o increments on every cpu_en_o-high cycle and saturates at 0xFFFF_FFFF without wrapping.
REQ-018 halted_pc_o and halt_cause_o hold their values until the next halt entry; a resume sets the cause to NONE.

Reset
REQ-019 Reset: state is RUN (or HALTED with cause EXTERNAL if START_HALTED = 1); all slots invalid; bp_skip, watchdog, cycle_count_o and halted_pc_o are 0; cause is NONE.
REQ-020 Reset overrides every other input in the same cycle, including mid-step or on a pending hit.

Structure
REQ-021 halt_cause_t (3-bit enum) is added to arch_defs_pkg.
REQ-022 Sub-module breakpoint_table holds the slots and write port and outputs a combinational match for pc_i.
REQ-023 The computer top gates all sequential enables with cpu_en_o, and drives hlt_i from the existing HLT decode.

Verification
REQ-024 HLT at addr 0 -> halt_o = 1, cause HLT, PC = 1, halted within 7 cycles of reset release.
REQ-025 Breakpoint at 0x3, program with no HLT before it -> cause BREAK, halted_pc_o = 0x3, instruction at 0x3 not executed; run_req_i -> execution continues past 0x3 without re-halting.
REQ-026 HALTED at 0x2 + step_req_i -> exactly one instruction executes, cause STEP, halted_pc_o = 0x3.
REQ-027 TIMEOUT_CYCLES = 20, infinite loop -> cause TIMEOUT after exactly 20 enabled cycles; cycle_count_o = 20.
REQ-028 Breakpoint write in the same cycle as pc_i matching the new address -> no halt on that pass, halt on the next pass.
REQ-029 Reset asserted in STEP -> next cycle state is RUN, all slots cleared, cycle_count_o = 0.

Source files
------------

// File: rtl/arch_defs_pkg.sv
// ---------------------------------------------------------------------------
// arch_defs_pkg
//   Shared architecture definitions for the CPU slice: program-counter width,
//   the halt-cause encoding reported by the run controller, the run
//   controller's state type and a helper for breakpoint-index widths.
// ---------------------------------------------------------------------------
package arch_defs_pkg;

  // Program-counter width used across the CPU.
  localparam int ADDR_WIDTH = 8;

  // Why the CPU last entered HALTED. NONE is reported while running, and
  // after a resume until the next halt.
  typedef enum logic [2:0] {
    HC_NONE     = 3'd0,
    HC_HLT      = 3'd1,
    HC_BREAK    = 3'd2,
    HC_STEP     = 3'd3,
    HC_TIMEOUT  = 3'd4,
    HC_EXTERNAL = 3'd5
  } halt_cause_t;

  // Run-control FSM states.
  typedef enum logic [1:0] {
    RC_RUN    = 2'd0,
    RC_STEP   = 2'd1,
    RC_HALTED = 2'd2
  } run_state_t;

  // Width of a breakpoint slot index; a single slot still gets a 1-bit index.
  function automatic int bp_idx_width(input int num_bp);
    return (num_bp > 1) ? $clog2(num_bp) : 1;
  endfunction

endpackage

// File: rtl/breakpoint_table.sv
// ---------------------------------------------------------------------------
// breakpoint_table
//   NUM_BP hardware breakpoint slots, each holding an address and an enable.
//   A write lands at the next clock edge, so a lookup in the same cycle as a
//   write still sees the old slot contents. The match output is purely
//   combinational on pc_i.
//
// Ports
//   clk, reset     clock and synchronous active-high reset (all slots invalid)
//   wr_en_i        slot write strobe
//   wr_idx_i       slot index to write (indices >= NUM_BP are ignored)
//   wr_addr_i      breakpoint address written into the slot
//   wr_valid_i     slot enable written with the address (0 disables the slot)
//   pc_i           address to look up
//   match_o        high when any enabled slot holds pc_i
// ---------------------------------------------------------------------------
module breakpoint_table
  import arch_defs_pkg::*;
#(
  parameter int ADDR_W = ADDR_WIDTH,
  parameter int NUM_BP = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            wr_en_i,
  input  logic [bp_idx_width(NUM_BP)-1:0] wr_idx_i,
  input  logic [ADDR_W-1:0]               wr_addr_i,
  input  logic                            wr_valid_i,
  input  logic [ADDR_W-1:0]               pc_i,
  output logic                            match_o
);

  localparam int IDX_W = bp_idx_width(NUM_BP);

  logic [NUM_BP-1:0] slot_hit;

  for (genvar gi = 0; gi < NUM_BP; gi++) begin : g_slot
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] addr_d;
    logic              valid_q;
    logic              valid_d;
    logic              wr_sel;

    assign wr_sel = wr_en_i && (wr_idx_i == IDX_W'(gi));

    always_comb begin
      addr_d  = addr_q;
      valid_d = valid_q;
      if (wr_sel) begin
        addr_d  = wr_addr_i;
        valid_d = wr_valid_i;
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        addr_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        addr_q  <= addr_d;
        valid_q <= valid_d;
      end
    end

    assign slot_hit[gi] = valid_q && (addr_q == pc_i);
  end

  assign match_o = |slot_hit;

endmodule

// File: rtl/run_control.sv
// ---------------------------------------------------------------------------
// run_control
//   Debug run controller for the CPU. Produces the CPU clock-enable and
//   stops the CPU on an HLT instruction, a hardware breakpoint, completion of
//   a single step, or a watchdog timeout. While halted, a run or step pulse
//   resumes execution. Counts enabled CPU cycles (saturating).
//
// Parameters
//   ADDR_W          program-counter width
//   NUM_BP          number of breakpoint slots (1..16)
//   TIMEOUT_CYCLES  watchdog limit in enabled RUN cycles, 0 disables it
//   START_HALTED    0: RUN after reset, 1: HALTED (cause EXTERNAL)
//
// Ports
//   clk, reset         clock and synchronous active-high reset
//   hlt_i              HLT decode strobe, one cycle during HLT execute
//   pc_i               current program counter
//   instr_boundary_i   high in the first fetch cycle of each instruction
//   run_req_i          resume pulse (honoured only while halted)
//   step_req_i         single-step pulse (honoured only while halted)
//   bp_wr_*            breakpoint slot write port
//   cpu_en_o           combinational CPU clock-enable
//   halt_o             registered, high in HALTED
//   halt_cause_o       registered halt_cause_t of the last halt
//   halted_pc_o        pc_i captured on halt entry
//   cycle_count_o      saturating count of cpu_en_o-high cycles
// ---------------------------------------------------------------------------
module run_control
  import arch_defs_pkg::*;
#(
  parameter int          ADDR_W         = ADDR_WIDTH,
  parameter int          NUM_BP         = 4,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter bit          START_HALTED   = 1'b0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            hlt_i,
  input  logic [ADDR_W-1:0]               pc_i,
  input  logic                            instr_boundary_i,
  input  logic                            run_req_i,
  input  logic                            step_req_i,
  input  logic                            bp_wr_en_i,
  input  logic [bp_idx_width(NUM_BP)-1:0] bp_wr_idx_i,
  input  logic [ADDR_W-1:0]               bp_wr_addr_i,
  input  logic                            bp_wr_valid_i,
  output logic                            cpu_en_o,
  output logic                            halt_o,
  output logic [2:0]                      halt_cause_o,
  output logic [ADDR_W-1:0]               halted_pc_o,
  output logic [31:0]                     cycle_count_o
);

  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);
  localparam bit          WD_ON    = (TIMEOUT_CYCLES != 0);

  run_state_t        state_q,     state_d;
  halt_cause_t       cause_q,     cause_d;
  logic              halt_q,      halt_d;
  logic [ADDR_W-1:0] halted_pc_q, halted_pc_d;
  logic [31:0]       cycle_cnt_q, cycle_cnt_d;
  logic [31:0]       wd_cnt_q,    wd_cnt_d;
  logic              bp_skip_q,   bp_skip_d;
  logic              step_seen_q, step_seen_d;

  logic bp_match;
  logic bp_hit;
  logic step_done;
  logic wd_expire;
  logic active;
  logic cpu_en;

  breakpoint_table #(
    .ADDR_W (ADDR_W),
    .NUM_BP (NUM_BP)
  ) u_bp_table (
    .clk        (clk),
    .reset      (reset),
    .wr_en_i    (bp_wr_en_i),
    .wr_idx_i   (bp_wr_idx_i),
    .wr_addr_i  (bp_wr_addr_i),
    .wr_valid_i (bp_wr_valid_i),
    .pc_i       (pc_i),
    .match_o    (bp_match)
  );

  assign active = (state_q == RC_RUN) || (state_q == RC_STEP);

  // bp_skip masks the breakpoint we just resumed from until the CPU has left
  // that instruction's fetch cycle.
  assign bp_hit = instr_boundary_i && bp_match && !bp_skip_q;

  // A step is finished at the first boundary after the stepped instruction
  // has made progress past its own fetch cycle.
  assign step_done = (state_q == RC_STEP) && instr_boundary_i && step_seen_q;

  assign wd_expire = WD_ON && (state_q == RC_RUN) && (wd_cnt_q == WD_LIMIT);

  // Any halting event other than HLT freezes the CPU in the same cycle; HLT
  // is allowed to complete.
  assign cpu_en = active && !bp_hit && !step_done && !wd_expire;

  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    halted_pc_d = halted_pc_q;
    cycle_cnt_d = cycle_cnt_q;
    wd_cnt_d    = wd_cnt_q;
    bp_skip_d   = bp_skip_q;
    step_seen_d = step_seen_q;

    if (cpu_en && (cycle_cnt_q != 32'hFFFF_FFFF)) begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
    end
    if (cpu_en && !instr_boundary_i) begin
      bp_skip_d = 1'b0;
    end
    if (cpu_en && !instr_boundary_i && (state_q == RC_STEP)) begin
      step_seen_d = 1'b1;
    end
    if (WD_ON && cpu_en && (state_q == RC_RUN)) begin
      wd_cnt_d = wd_cnt_q + 32'd1;
    end

    case (state_q)
      RC_RUN, RC_STEP: begin
        // Priority: HLT > BREAK > STEP > TIMEOUT.
        if (hlt_i) begin
          state_d     = RC_HALTED;
          cause_d     = HC_HLT;
          halted_pc_d = pc_i;
        end else if (bp_hit) begin
          state_d     = RC_HALTED;
          cause_d     = HC_BREAK;
          halted_pc_d = pc_i;
        end else if (step_done) begin
          state_d     = RC_HALTED;
          cause_d     = HC_STEP;
          halted_pc_d = pc_i;
        end else if (wd_expire) begin
          state_d     = RC_HALTED;
          cause_d     = HC_TIMEOUT;
          halted_pc_d = pc_i;
        end
      end
      RC_HALTED: begin
        if (run_req_i) begin
          state_d   = RC_RUN;
          cause_d   = HC_NONE;
          bp_skip_d = 1'b1;
          wd_cnt_d  = '0;
        end else if (step_req_i) begin
          state_d     = RC_STEP;
          cause_d     = HC_NONE;
          bp_skip_d   = 1'b1;
          step_seen_d = 1'b0;
        end
      end
      default: begin
        // Unreachable encoding: park the CPU rather than let it run blind.
        state_d = RC_HALTED;
        cause_d = HC_EXTERNAL;
      end
    endcase

    halt_d = (state_d == RC_HALTED);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= START_HALTED ? RC_HALTED : RC_RUN;
      cause_q     <= START_HALTED ? HC_EXTERNAL : HC_NONE;
      halt_q      <= START_HALTED;
      halted_pc_q <= '0;
      cycle_cnt_q <= '0;
      wd_cnt_q    <= '0;
      bp_skip_q   <= 1'b0;
      step_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      halt_q      <= halt_d;
      halted_pc_q <= halted_pc_d;
      cycle_cnt_q <= cycle_cnt_d;
      wd_cnt_q    <= wd_cnt_d;
      bp_skip_q   <= bp_skip_d;
      step_seen_q <= step_seen_d;
    end
  end

  assign cpu_en_o      = cpu_en;
  assign halt_o        = halt_q;
  assign halt_cause_o  = cause_q;
  assign halted_pc_o   = halted_pc_q;
  assign cycle_count_o = cycle_cnt_q;

endmodule

// File: tb/tb_run_control.sv
// ---------------------------------------------------------------------------
// tb_run_control
//   Drives run_control from a tiny CPU model (every instruction takes three
//   enabled cycles: fetch, decode, execute; ops are NOP, HLT and JMP). An
//   instruction-level reference model predicts each halt (cause, captured PC,
//   enabled-cycle count) when a resume is issued; a monitor pops and compares
//   on every halt entry.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_run_control;
  import arch_defs_pkg::*;

  localparam int AW  = 8;
  localparam int NBP = 4;
  localparam int IW  = 2;
  localparam int TMO = 20;

  logic          clk = 1'b0;
  logic          reset;
  logic          hlt_i;
  logic [AW-1:0] pc_i;
  logic          instr_boundary_i;
  logic          run_req_i;
  logic          step_req_i;
  logic          bp_wr_en_i;
  logic [IW-1:0] bp_wr_idx_i;
  logic [AW-1:0] bp_wr_addr_i;
  logic          bp_wr_valid_i;
  logic          cpu_en_o;
  logic          halt_o;
  logic [2:0]    halt_cause_o;
  logic [AW-1:0] halted_pc_o;
  logic [31:0]   cycle_count_o;

  always #5 clk = ~clk;

  run_control #(
    .ADDR_W         (AW),
    .NUM_BP         (NBP),
    .TIMEOUT_CYCLES (TMO),
    .START_HALTED   (1'b0)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .hlt_i            (hlt_i),
    .pc_i             (pc_i),
    .instr_boundary_i (instr_boundary_i),
    .run_req_i        (run_req_i),
    .step_req_i       (step_req_i),
    .bp_wr_en_i       (bp_wr_en_i),
    .bp_wr_idx_i      (bp_wr_idx_i),
    .bp_wr_addr_i     (bp_wr_addr_i),
    .bp_wr_valid_i    (bp_wr_valid_i),
    .cpu_en_o         (cpu_en_o),
    .halt_o           (halt_o),
    .halt_cause_o     (halt_cause_o),
    .halted_pc_o      (halted_pc_o),
    .cycle_count_o    (cycle_count_o)
  );

  // ---------------- CPU model (stimulus source) ----------------
  typedef enum logic [1:0] {OP_NOP, OP_HLT, OP_JMP} op_t;
  op_t           prog_op  [256];
  logic [AW-1:0] prog_tgt [256];
  logic [AW-1:0] cpu_addr;
  int            cpu_phase;

  always @(posedge clk) begin
    if (reset) begin
      cpu_addr  <= '0;
      cpu_phase <= 0;
    end else if (cpu_en_o) begin
      if (cpu_phase == 2) begin
        cpu_phase <= 0;
        cpu_addr  <= (prog_op[cpu_addr] == OP_JMP) ? prog_tgt[cpu_addr] : cpu_addr + 8'd1;
      end else begin
        cpu_phase <= cpu_phase + 1;
      end
    end
  end

  // PC advances past the instruction after its fetch cycle.
  assign instr_boundary_i = (cpu_phase == 0);
  assign pc_i             = (cpu_phase == 0) ? cpu_addr : cpu_addr + 8'd1;
  assign hlt_i            = (prog_op[cpu_addr] == OP_HLT) && (cpu_phase == 2) && cpu_en_o;

  // ---------------- reference model + scoreboard ----------------
  typedef struct packed {
    logic [2:0]    cause;
    logic [AW-1:0] pc;
    logic [31:0]   cyc;
  } exp_t;

  exp_t          exp_q[$];
  bit            m_bp_valid [NBP];
  logic [AW-1:0] m_bp_addr  [NBP];
  logic [AW-1:0] m_addr;
  int            m_phase;
  int unsigned   m_cyc;

  int n_tests = 0;
  int n_fail  = 0;
  int n_halts = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  function automatic bit m_bp_at(input logic [AW-1:0] a);
    for (int i = 0; i < NBP; i++) begin
      if (m_bp_valid[i] && (m_bp_addr[i] == a)) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Walk the program from the current position until the next halt and
  // queue the expected halt record.
  task automatic model_resume(input bit is_step, input bit skip_init);
    int            wd   = 0;
    bit            seen = 1'b0;
    bit            skip = skip_init;
    bit            done = 1'b0;
    exp_t          e;
    logic [AW-1:0] pc_view;
    e.cause = HC_NONE;
    e.pc    = '0;
    for (int n = 0; (n < 1000) && !done; n++) begin
      pc_view = (m_phase == 0) ? m_addr : m_addr + 8'd1;
      if ((m_phase == 0) && !skip && m_bp_at(m_addr)) begin
        e.cause = HC_BREAK;  e.pc = m_addr;  done = 1'b1;
      end else if (is_step && (m_phase == 0) && seen) begin
        e.cause = HC_STEP;   e.pc = m_addr;  done = 1'b1;
      end else if (!is_step && (wd == TMO)) begin
        e.cause = HC_TIMEOUT; e.pc = pc_view; done = 1'b1;
      end else begin
        m_cyc++;
        if (!is_step) wd++;
        if (m_phase != 0) begin
          skip = 1'b0;
          seen = 1'b1;
        end
        if (m_phase == 2) begin
          if (prog_op[m_addr] == OP_HLT) begin
            e.cause = HC_HLT; e.pc = m_addr + 8'd1; done = 1'b1;
          end
          m_addr  = (prog_op[m_addr] == OP_JMP) ? prog_tgt[m_addr] : m_addr + 8'd1;
          m_phase = 0;
        end else begin
          m_phase++;
        end
      end
    end
    e.cyc = m_cyc;
    exp_q.push_back(e);
  endtask

  // Monitor: compare on each halt entry.
  initial begin
    logic halt_prev;
    exp_t e;
    halt_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        halt_prev = 1'b0;
      end else begin
        if ((halt_o === 1'b1) && !halt_prev) begin
          n_halts++;
          $display("[TB] halt %0d: cause=%0d pc=0x%0h cycles=%0d", n_halts, halt_cause_o, halted_pc_o, cycle_count_o);
          if (exp_q.size() == 0) begin
            check("unexpected_halt", 32'(halt_cause_o), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("halt_cause", 32'(halt_cause_o), 32'(e.cause));
            check("halted_pc", 32'(halted_pc_o), 32'(e.pc));
            check("cycle_count", cycle_count_o, e.cyc);
            check("cpu_en_halted", 32'(cpu_en_o), 32'd0);
          end
        end
        halt_prev = halt_o;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_halt(input string what, output int waited);
    int i;
    for (i = 0; i < 200; i++) begin
      if (halt_o === 1'b1) break;
      @(negedge clk);
    end
    waited = i;
    if (i == 200) begin
      n_tests++;
      n_fail++;
      $display("FAIL halt_wait_%s: no halt within 200 cycles, required a halt", what);
    end
  endtask

  task automatic build_program(input int ep);
    int r;
    for (int a = 0; a < 256; a++) begin
      prog_op[a]  = OP_NOP;
      prog_tgt[a] = '0;
    end
    for (int a = 0; a < 32; a++) begin
      r = $urandom_range(0, 99);
      if (r < 12)      prog_op[a] = OP_HLT;
      else if (r < 30) prog_op[a] = OP_JMP;
      prog_tgt[a] = AW'($urandom_range(0, 31));
    end
    prog_op[31] = OP_JMP;
    if (ep == 0) prog_op[0] = OP_HLT;
  endtask

  task automatic bp_write(input int idx, input logic [AW-1:0] addr, input bit valid);
    bp_wr_en_i    = 1'b1;
    bp_wr_idx_i   = IW'(idx);
    bp_wr_addr_i  = addr;
    bp_wr_valid_i = valid;
    @(negedge clk);
    bp_wr_en_i    = 1'b0;
    m_bp_valid[idx] = valid;
    m_bp_addr[idx]  = addr;
  endtask

  initial begin
    int waited;
    int nw;
    reset         = 1'b1;
    run_req_i     = 1'b0;
    step_req_i    = 1'b0;
    bp_wr_en_i    = 1'b0;
    bp_wr_idx_i   = '0;
    bp_wr_addr_i  = '0;
    bp_wr_valid_i = 1'b0;
    build_program(0);

    for (int ep = 0; ep < 3; ep++) begin
      build_program(ep);
      exp_q.delete();
      for (int i = 0; i < NBP; i++) begin
        m_bp_valid[i] = 1'b0;
        m_bp_addr[i]  = '0;
      end
      m_addr  = '0;
      m_phase = 0;
      m_cyc   = 0;
      reset   = 1'b1;
      repeat (2) @(negedge clk);
      check("reset_halt", 32'(halt_o), 32'd0);
      check("reset_cause", 32'(halt_cause_o), 32'(HC_NONE));
      check("reset_cycle_count", cycle_count_o, 32'd0);
      check("reset_halted_pc", 32'(halted_pc_o), 32'd0);
      check("reset_cpu_en", 32'(cpu_en_o), 32'd1);

      model_resume(1'b0, 1'b0);
      reset = 1'b0;
      wait_halt("after_reset", waited);
      if (ep == 0) check("hlt_at_0_latency_ok", 32'(waited <= 7), 32'd1);

      for (int t = 0; t < 30; t++) begin
        nw = $urandom_range(0, 2);
        for (int w = 0; w < nw; w++) begin
          bp_write($urandom_range(0, NBP - 1), AW'($urandom_range(0, 31)), ($urandom_range(0, 3) != 0));
        end
        if ($urandom_range(0, 9) < 6) begin
          run_req_i  = 1'b1;
          step_req_i = ($urandom_range(0, 3) == 0);
          model_resume(1'b0, 1'b1);
        end else begin
          step_req_i = 1'b1;
          model_resume(1'b1, 1'b1);
        end
        @(negedge clk);
        run_req_i  = 1'b0;
        step_req_i = 1'b0;
        wait_halt("resume", waited);
      end

      // Abort a step with reset; the step's halt must never appear.
      if (ep < 2) begin
        step_req_i = 1'b1;
        @(negedge clk);
        step_req_i = 1'b0;
        reset      = 1'b1;
        exp_q.delete();
      end
    end

    repeat (4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "global timeout");
  end

endmodule
